ldl_hs_master: RTL and testbench
================================

// Module: ldl_hs_master
// PURPOSE
//  Clock-domain master side of the LDL 4-phase req/ack link in clk_m domain.
//  - Accepts single Wishbone classic cycles from the local bus.
//  - Drives req_o with address, write data and we to the remote domain.
//  - Consumes the already-synchronised ack (output of the 3-flop ack synchroniser).
//  - Returns wb_ack_o/wb_err_o to the local bus.
// PARAMETERS
//  AW        8    address width
//  DW        32   data width
//  TO_W      8    timeout counter width
//  TO_CYCLES 200  clk_m cycles in REQ before timeout; 0 disables timeout
// PORTS
//  clk_m       in   1    master-domain clock
//  reset_m     in   1    asynchronous, active-low reset
//  wb_cyc_i    in   1    Wishbone cycle
//  wb_stb_i    in   1    Wishbone strobe
//  wb_we_i     in   1    1=write, 0=read
//  wb_adr_i    in   AW   transfer address
//  wb_dat_i    in   DW   write data
//  wb_dat_o    out  DW   read data, valid with wb_ack_o
//  wb_ack_o    out  1    one-cycle transfer-complete pulse
//  wb_err_o    out  1    one-cycle timeout-error pulse
//  req_o       out  1    4-phase request to remote domain
//  adr_o       out  AW   address, stable while req_o=1
//  dat_o       out  DW   write data, stable while req_o=1
//  we_o        out  1    direction, stable while req_o=1
//  rdat_i      in   DW   remote read data; stable while remote ack is high
//  ack_sync_i  in   1    remote ack, already synchronised into clk_m
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; timeout counter=0.
//  FSM states:
//   IDLE
//    - Exit to REQ when cyc&stb=1 and ack_sync_i=0.
//    - On that edge, register adr/dat/we; req_o<=1.
//    - If ack_sync_i=1 (stale or spurious), stay in IDLE.
//   REQ
//    - On ack_sync_i=1:
//      - req_o<=0.
//      - wb_dat_o<=rdat_i on reads; hold previous value on writes.
//      - wb_ack_o<=1 for exactly 1 cycle.
//      - Go to REL.
//    - Else counter++. When counter==TO_CYCLES-1 (TO_CYCLES!=0):
//      - req_o<=0; wb_err_o<=1 for 1 cycle.
//      - Go to REL.
//   REL
//    - Wait ack_sync_i=0, then go to IDLE.
//    - No timeout in REL.
//    - New strobes are held off: no ack, no err.
//  Counter: cleared on IDLE->REQ; saturates, never wraps.
//  Latency:
//    - IDLE->req_o high: 1 cycle.
//    - ack_sync_i rise -> wb_ack_o: 1 cycle.
//    - Minimum back-to-back spacing: REQ + REL + 1 idle cycle.
//  adr_o/dat_o/we_o: change only on IDLE->REQ; otherwise hold.
//  Simultaneous ack_sync_i rise and timeout expiry: ack wins, no err.
//  stb dropped during REQ: remote transfer still completes; wb_ack_o suppressed.
//  Reset mid-transfer: req_o falls asynchronously; state returns to IDLE.
//    The remote side must tolerate req falling before ack.
//  wb_ack_o and wb_err_o are never high in the same cycle.
// STRUCTURE
//  - State encodings (IDLE=2'd0, REQ=2'd1, REL=2'd2) go in the shared LDL defines include.
//  - TO_CYCLES default also goes in that include.
//  - ack_sync_i comes from the existing ack synchroniser instantiated in the parent.
//  - One sub-module: ldl_to_counter. It takes clear, enable and limit; outputs expire.
// TESTING
//  1. Write adr=8'h12 dat=32'hA5A5_0001:
//     - req_o rises 1 cycle after stb, with adr_o=8'h12.
//     - Raise ack_sync 5 cycles later -> wb_ack_o 1 cycle; req_o low.
//  2. Read with rdat_i=32'hDEAD_BEEF:
//     - wb_dat_o=32'hDEAD_BEEF in the wb_ack_o cycle.
//     - Next strobe waits until ack_sync_i falls.
//  3. No ack, TO_CYCLES=200:
//     - wb_err_o pulses exactly 200 cycles after req_o rose; req_o low; no wb_ack_o.
//  4. ack_sync rises in the expiry cycle:
//     - wb_ack_o=1, wb_err_o=0.
//  5. reset_m low while in REQ:
//     - req_o=0 with no clock edge needed; all outputs 0.
//     - After release, a fresh write completes normally.
//  6. Back-to-back strobes with ack_sync held high 10 cycles:
//     - Second req_o rises only after ack_sync falls.
//     - Exactly one wb_ack_o per transfer.

Source files
------------

// File: rtl/ldl_hs_master_pkg.sv
// ---------------------------------------------------------------------------
// ldl_hs_master_pkg
//  Shared definitions for the LDL 4-phase req/ack link, master side.
//  - ldl_state_e        : handshake FSM state encoding
//  - LDL_TO_CYCLES_DEF  : default number of clk_m cycles spent in REQ before
//                         the transfer is abandoned with an error
//  - ldl_to_limit       : converts a cycle count into the counter's limit width
// ---------------------------------------------------------------------------
package ldl_hs_master_pkg;

    typedef enum logic [1:0] {
        LDL_IDLE = 2'd0,
        LDL_REQ  = 2'd1,
        LDL_REL  = 2'd2
    } ldl_state_e;

    localparam int LDL_TO_CYCLES_DEF = 200;

    // A limit of zero means "never expire"; the value is simply truncated to
    // the counter width, so callers must pick a width that holds it.
    function automatic logic [15:0] ldl_to_limit(input int cycles);
        return 16'(cycles);
    endfunction

endpackage

// File: rtl/ldl_to_counter.sv
// ---------------------------------------------------------------------------
// ldl_to_counter
//  Saturating cycle counter used to time out an unanswered request.
//  Ports:
//   clk_m    in   master-domain clock
//   reset_m  in   asynchronous active-low reset
//   clear    in   restart the count at zero (has priority over enable)
//   enable   in   advance the count by one this cycle
//   limit    in   expiry threshold in cycles; 0 disables expiry
//   expire   out  high while count == limit-1, i.e. on the limit-th cycle
// ---------------------------------------------------------------------------
module ldl_to_counter #(
    parameter int TO_W = 8
) (
    input  logic            clk_m,
    input  logic            reset_m,
    input  logic            clear,
    input  logic            enable,
    input  logic [TO_W-1:0] limit,
    output logic            expire
);

    logic [TO_W-1:0] count_reg;
    logic [TO_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != {TO_W{1'b1}})) begin
            // Saturate at all-ones so a stuck request can never wrap around
            // and appear "fresh" again.
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_m or negedge reset_m) begin
        if (!reset_m) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = (limit != '0) && (count_reg == (limit - 1'b1));

endmodule

// File: rtl/ldl_hs_master.sv
// ---------------------------------------------------------------------------
// ldl_hs_master
//  Master side of the LDL 4-phase req/ack link, clk_m domain. Turns single
//  Wishbone classic cycles into a req/ack handshake towards a remote domain
//  and returns ack (or a timeout error) to the local bus.
//  Ports:
//   clk_m, reset_m         clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i     Wishbone cycle / strobe
//   wb_we_i                1 = write, 0 = read
//   wb_adr_i, wb_dat_i     transfer address / write data
//   wb_dat_o               read data, valid with wb_ack_o
//   wb_ack_o, wb_err_o     one-cycle completion / timeout pulses
//   req_o                  4-phase request to remote domain
//   adr_o, dat_o, we_o     transfer fields, stable while req_o = 1
//   rdat_i                 remote read data, stable while remote ack is high
//   ack_sync_i             remote ack, already synchronised into clk_m
// ---------------------------------------------------------------------------
module ldl_hs_master
    import ldl_hs_master_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int TO_W      = 8,
    parameter int TO_CYCLES = LDL_TO_CYCLES_DEF
) (
    input  logic          clk_m,
    input  logic          reset_m,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          req_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    output logic          we_o,
    input  logic [DW-1:0] rdat_i,
    input  logic          ack_sync_i
);

    localparam logic [15:0]     LIMIT_FULL = ldl_to_limit(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LIMIT   = LIMIT_FULL[TO_W-1:0];

    ldl_state_e    state_reg, state_next;
    logic          req_reg, req_next;
    logic          ack_reg, ack_next;
    logic          err_reg, err_next;
    logic [DW-1:0] rdat_reg, rdat_next;
    logic [AW-1:0] adr_reg, adr_next;
    logic [DW-1:0] wdat_reg, wdat_next;
    logic          we_reg, we_next;

    logic          cnt_clear;
    logic          cnt_enable;
    logic          cnt_expire;
    logic          wb_active;

    assign wb_active = wb_cyc_i & wb_stb_i;

    ldl_to_counter #(
        .TO_W (TO_W)
    ) u_to_counter (
        .clk_m   (clk_m),
        .reset_m (reset_m),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .limit   (TO_LIMIT),
        .expire  (cnt_expire)
    );

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        rdat_next  = rdat_reg;
        adr_next   = adr_reg;
        wdat_next  = wdat_reg;
        we_next    = we_reg;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_reg)
            LDL_IDLE: begin
                // A still-high ack here is left over from the previous
                // handshake (or spurious); starting now would break 4-phase.
                if (wb_active && !ack_sync_i) begin
                    state_next = LDL_REQ;
                    req_next   = 1'b1;
                    adr_next   = wb_adr_i;
                    wdat_next  = wb_dat_i;
                    we_next    = wb_we_i;
                    cnt_clear  = 1'b1;
                end
            end
            LDL_REQ: begin
                // Ack is tested first so it wins over a same-cycle expiry.
                if (ack_sync_i) begin
                    req_next   = 1'b0;
                    // Remote transfer completes regardless; the bus only
                    // sees the ack if the master is still waiting for it.
                    ack_next   = wb_active;
                    if (!we_reg) begin
                        rdat_next = rdat_i;
                    end
                    state_next = LDL_REL;
                end else begin
                    cnt_enable = 1'b1;
                    if (cnt_expire) begin
                        req_next   = 1'b0;
                        err_next   = 1'b1;
                        state_next = LDL_REL;
                    end
                end
            end
            LDL_REL: begin
                // Wait for the remote side to finish its half of the
                // handshake; new strobes are simply not serviced yet.
                if (!ack_sync_i) begin
                    state_next = LDL_IDLE;
                end
            end
            default: begin
                state_next = LDL_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_m or negedge reset_m) begin
        if (!reset_m) begin
            state_reg <= LDL_IDLE;
            req_reg   <= 1'b0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdat_reg  <= '0;
            adr_reg   <= '0;
            wdat_reg  <= '0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            rdat_reg  <= rdat_next;
            adr_reg   <= adr_next;
            wdat_reg  <= wdat_next;
            we_reg    <= we_next;
        end
    end

    assign req_o    = req_reg;
    assign wb_ack_o = ack_reg;
    assign wb_err_o = err_reg;
    assign wb_dat_o = rdat_reg;
    assign adr_o    = adr_reg;
    assign dat_o    = wdat_reg;
    assign we_o     = we_reg;

endmodule

// File: tb/tb_ldl_hs_master.sv
module tb_ldl_hs_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 200;

    logic          clk_m = 1'b0;
    logic          reset_m;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic          req_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic          we_o;
    logic [DW-1:0] rdat_i;
    logic          ack_sync_i;

    int total = 0;
    int bad   = 0;
    int xfer_no = 0;
    logic [DW-1:0] last_rd;   // model: value wb_dat_o must be holding

    ldl_hs_master #(
        .AW        (AW),
        .DW        (DW),
        .TO_W      (8),
        .TO_CYCLES (TO)
    ) dut (
        .clk_m      (clk_m),
        .reset_m    (reset_m),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .req_o      (req_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .we_o       (we_o),
        .rdat_i     (rdat_i),
        .ack_sync_i (ack_sync_i)
    );

    always #5 clk_m = ~clk_m;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_m);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"}, 64'(req_o), 64'd0);
        check_val({tag, "_ack"}, 64'(wb_ack_o), 64'd0);
        check_val({tag, "_err"}, 64'(wb_err_o), 64'd0);
        check_val({tag, "_rdat"}, 64'(wb_dat_o), 64'd0);
        check_val({tag, "_fields"}, 64'({adr_o, dat_o, we_o}), 64'd0);
    endtask

    // One Wishbone transfer. d = cycles after req_o rises before ack_sync_i
    // is raised (>= TO means it never answers in time). hold = extra cycles
    // ack stays high after the bus sees the result. drop = master abandons
    // stb right after req rises. keep = master leaves stb high for the next
    // transfer (back-to-back).
    task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int d, input int hold,
                        input bit drop, input bit keep);
        bit exp_ack;
        int exp_done, exp_end, exp_ack_cnt, exp_err_cnt;
        int ack_cnt = 0, err_cnt = 0, ack_at = -1, err_at = -1, req_fall = -1;
        int both = 0, unstable = 0, tail_req = 0;
        bit ack_raised = 0;
        logic [DW-1:0] dat_at_ack = '0;

        exp_ack     = (d < TO);
        exp_done    = exp_ack ? d + 1 : TO;
        exp_end     = exp_done + 2;
        exp_ack_cnt = (exp_ack && !drop) ? 1 : 0;
        exp_err_cnt = exp_ack ? 0 : 1;
        if (exp_ack && !we) last_rd = rd;

        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd; rdat_i = rd;
        check_val("req_pre", 64'(req_o), 64'd0);
        tick();
        check_val("req_rise", 64'(req_o), 64'd1);
        check_val("fields", 64'({adr_o, dat_o, we_o}), 64'({adr, wd, we}));

        for (int n = 1; n <= exp_end; n++) begin
            if (!ack_raised && (n - 1 == d)) begin
                ack_sync_i = 1'b1;
                ack_raised = 1'b1;
            end
            if (drop && n == 1) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            tick();
            if (wb_ack_o) begin ack_cnt++; ack_at = n; dat_at_ack = wb_dat_o; end
            if (wb_err_o) begin err_cnt++; err_at = n; end
            if (wb_ack_o && wb_err_o) both++;
            if (!req_o && req_fall < 0) req_fall = n;
            if (adr_o !== adr || dat_o !== wd || we_o !== we) unstable++;
            if ((wb_ack_o || wb_err_o) && !keep) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end

        if (ack_raised) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                if (wb_ack_o) ack_cnt++;
                if (wb_err_o) err_cnt++;
                if (req_o) tail_req++;
            end
            ack_sync_i = 1'b0;
            tick();
            if (wb_ack_o) ack_cnt++;
            if (wb_err_o) err_cnt++;
            if (req_o) tail_req++;
        end

        check_val("ack_count", 64'(ack_cnt), 64'(exp_ack_cnt));
        check_val("err_count", 64'(err_cnt), 64'(exp_err_cnt));
        check_val("req_fall_cycle", 64'(req_fall), 64'(exp_done));
        check_val("ack_err_overlap", 64'(both), 64'd0);
        check_val("fields_stable", 64'(unstable), 64'd0);
        check_val("req_held_off", 64'(tail_req), 64'd0);
        if (exp_ack_cnt == 1) begin
            check_val("ack_cycle", 64'(ack_at), 64'(exp_done));
            check_val("rdat_at_ack", 64'(dat_at_ack), 64'(last_rd));
        end
        if (exp_err_cnt == 1) check_val("err_cycle", 64'(err_at), 64'(TO));
        check_val("rdat_hold", 64'(wb_dat_o), 64'(last_rd));

        xfer_no++;
        $display("xfer %0d we=%0b adr=%02h d=%0d hold=%0d drop=%0b keep=%0b -> ack=%0d err=%0d",
                 xfer_no, we, adr, d, hold, drop, keep, ack_cnt, err_cnt);
    endtask

    initial begin
        reset_m = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; rdat_i = '0; ack_sync_i = 1'b0;
        last_rd = '0;

        repeat (3) tick();
        check_all_zero("reset");
        reset_m = 1'b1;
        tick();
        check_val("post_reset_req", 64'(req_o), 64'd0);

        // Directed: write, read with back-to-back follow-up, timeout,
        // ack in the expiry cycle, late and stale acks.
        xfer(1'b1, 8'h12, 32'hA5A5_0001, 32'h0, 5, 0, 1'b0, 1'b0);
        xfer(1'b0, 8'h34, 32'h0, 32'hDEAD_BEEF, 3, 4, 1'b0, 1'b1);
        xfer(1'b1, 8'h35, 32'h1234_5678, 32'h0, 2, 10, 1'b0, 1'b1);
        xfer(1'b0, 8'h36, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b0);
        xfer(1'b0, 8'h40, 32'h0, 32'h1111_2222, 1000, 0, 1'b0, 1'b0);
        xfer(1'b0, 8'h41, 32'h0, 32'h3333_4444, TO - 1, 1, 1'b0, 1'b0);
        xfer(1'b1, 8'h42, 32'h5555_6666, 32'h0, TO, 2, 1'b0, 1'b0);
        xfer(1'b0, 8'h43, 32'h0, 32'h7777_8888, 4, 1, 1'b1, 1'b0);

        // Reset while a request is outstanding: outputs clear without an edge.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 8'h5A; wb_dat_i = 32'h0BAD_0BAD;
        tick();
        check_val("rst_req_up", 64'(req_o), 64'd1);
        repeat (3) tick();
        #3 reset_m = 1'b0;
        #1;
        check_all_zero("async_reset");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        reset_m = 1'b1;
        last_rd = '0;
        tick();
        xfer(1'b1, 8'h5B, 32'h600D_600D, 32'h0, 6, 0, 1'b0, 1'b0);

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            int r, d, hold;
            bit drop, keep;
            r = $urandom_range(0, 9);
            if (r < 7)       d = $urandom_range(0, 15);
            else if (r == 7) d = TO - 2 + $urandom_range(0, 3);
            else             d = 1000;
            hold = $urandom_range(0, 5);
            drop = (d < TO) && ($urandom_range(0, 5) == 0);
            keep = !drop && (d < TO) && ($urandom_range(0, 1) == 1);
            xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, d, hold, drop, keep);
        end
        xfer(1'b0, 8'hFF, 32'h0, 32'h0F0F_F0F0, 7, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on run time in case the bench itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
